my_or_gate: RTL and testbench



---
 rtl/my_or_gate.sv | 33 +++
 tb/tb_my_or_gate.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/my_or_gate.sv
// Two-input OR with a purely combinational result, a registered copy of it,
// and a saturating count of 0->1 transitions of the registered copy.
module my_or_gate #(
  parameter int CNT_W = 8
) (
  output logic             out,
  input  logic             a,
  input  logic             b,
  input  logic             clk,
  input  logic             rst_n,
  output logic             out_q,
  output logic [CNT_W-1:0] rise_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign out = a | b;

  // A rise is counted on the same edge that moves out_q from 0 to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= 1'b0;
      rise_cnt <= '0;
    end else begin
      out_q <= out;
      if (!out_q && out && (rise_cnt != CNT_MAX)) begin
        rise_cnt <= rise_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_my_or_gate.sv
// Directed bench for my_or_gate: combinational truth table, registered path,
// async reset, simultaneous input change and counter saturation at CNT_W = 2.
module tb_my_or_gate;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       a, b;
  logic       a2, b2;
  logic       out, out_q;
  logic [7:0] rise_cnt;
  logic       out2, out_q2;
  logic [1:0] rise_cnt2;

  int total;
  int bad;

  my_or_gate #(.CNT_W(8)) dut (
    .out      (out),
    .a        (a),
    .b        (b),
    .clk      (clk),
    .rst_n    (rst_n),
    .out_q    (out_q),
    .rise_cnt (rise_cnt)
  );

  my_or_gate #(.CNT_W(2)) dut_sat (
    .out      (out2),
    .a        (a2),
    .b        (b2),
    .clk      (clk),
    .rst_n    (rst_n),
    .out_q    (out_q2),
    .rise_cnt (rise_cnt2)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [1:0] vec_ab  [4];
    logic       vec_out [4];
    int         exp_cnt2 [10];
    logic       exp_q2   [10];

    vec_ab   = '{2'b00, 2'b10, 2'b01, 2'b11};
    vec_out  = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_cnt2 = '{1, 1, 2, 2, 3, 3, 3, 3, 3, 3};
    exp_q2   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    total  = 0;
    bad    = 0;
    clk    = 1'b0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    a      = 1'b0;
    b      = 1'b0;
    a2     = 1'b0;
    b2     = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_out_q", {7'd0, out_q}, 8'd0);
    check("reset_cnt", rise_cnt, 8'd0);
    check("reset_out_q2", {7'd0, out_q2}, 8'd0);
    check("reset_cnt2", {6'd0, rise_cnt2}, 8'd0);

    // Truth table with no clock running and reset asserted.
    for (int i = 0; i < 4; i++) begin
      a = vec_ab[i][1];
      b = vec_ab[i][0];
      #10;
      check($sformatf("comb_%0d%0d", a, b), {7'd0, out}, {7'd0, vec_out[i]});
    end
    check("comb_no_clk_out_q", {7'd0, out_q}, 8'd0);

    a = 1'b0;
    b = 1'bx;
    #1;
    check("comb_0_or_x", {7'd0, out}, {7'd0, 1'bx});
    a = 1'b1;
    #1;
    check("comb_1_or_x", {7'd0, out}, 8'd1);
    a = 1'b0;
    b = 1'b0;
    #1;

    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_out_q", {7'd0, out_q}, 8'd0);
    check("idle_cnt", rise_cnt, 8'd0);

    // Registered path.
    @(negedge clk);
    a = 1'b1;
    tick();
    check("reg_out_q_hi", {7'd0, out_q}, 8'd1);
    check("reg_cnt_1", rise_cnt, 8'd1);
    @(negedge clk);
    a = 1'b0;
    b = 1'b0;
    tick();
    check("reg_out_q_lo", {7'd0, out_q}, 8'd0);
    check("reg_cnt_hold", rise_cnt, 8'd1);

    // Glitch between edges.
    @(negedge clk);
    #1 a = 1'b1;
    #0;
    #1;
    check("glitch_out_hi", {7'd0, out}, 8'd1);
    a = 1'b0;
    #1;
    check("glitch_out_lo", {7'd0, out}, 8'd0);
    check("glitch_out_q", {7'd0, out_q}, 8'd0);
    check("glitch_cnt", rise_cnt, 8'd1);
    tick();
    check("glitch_cnt_after", rise_cnt, 8'd1);

    // Second rise, then a and b swap at the same instant.
    @(negedge clk);
    a = 1'b1;
    tick();
    check("rise2_cnt", rise_cnt, 8'd2);
    @(negedge clk);
    a = 1'b0; b = 1'b1;
    #1;
    check("swap_out", {7'd0, out}, 8'd1);
    tick();
    check("swap_out_q", {7'd0, out_q}, 8'd1);
    check("swap_cnt", rise_cnt, 8'd2);

    // Async reset mid-run with out_q = 1 and rise_cnt = 2.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_q", {7'd0, out_q}, 8'd0);
    check("arst_cnt", rise_cnt, 8'd0);
    check("arst_out", {7'd0, out}, 8'd1);
    tick();
    check("arst_hold_out_q", {7'd0, out_q}, 8'd0);
    check("arst_hold_cnt", rise_cnt, 8'd0);

    // Release with a | b = 1: reset value of out_q counts as 0.
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("release_out_q", {7'd0, out_q}, 8'd1);
    check("release_cnt", rise_cnt, 8'd1);

    // Saturation with CNT_W = 2.
    check("sat_start_cnt2", {6'd0, rise_cnt2}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a2 = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("sat_q_%0d", i), {7'd0, out_q2}, {7'd0, exp_q2[i]});
      check($sformatf("sat_cnt_%0d", i), {6'd0, rise_cnt2}, exp_cnt2[i][7:0]);
    end
    check("sat_other_cnt", rise_cnt, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
